// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a 2-entry skid; 1-cycle latency when empty or draining.
// in_ready depends only on held state, so downstream backpressure never reaches upstream combinationally.
module pipe_stage_skid #(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  RESET_VAL = DATA_W'(64'h13)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        level
);

    // State value equals the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_d;
    logic              push;
    logic              pop;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_d;
    assign level     = state;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready & ~stall;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            // Skid contents are left as-is; they are unreachable once empty.
            state  <= EMPTY;
            main_d <= RESET_VAL;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state  <= ONE;
                        main_d <= in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d <= in_data;
                    end else if (push) begin
                        state  <= FULL;
                        skid_d <= in_data;
                    end else if (pop) begin
                        state  <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state  <= ONE;
                        main_d <= skid_d;
                    end
                end
                default: begin
                    state  <= EMPTY;
                    main_d <= RESET_VAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench: the reference is a bounded queue of accepted payloads (capacity 2).
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [1:0]  level;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] q[$];
    bit          armed = 0;
    bit          fresh = 0;

    localparam logic [63:0] NOP = 64'h13;

    pipe_stage_skid #(.DATA_W(64), .RESET_VAL(NOP)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: state checks against queue occupancy, payload checks on every pop.
    always @(negedge clk) begin
        logic [63:0] exp_d;
        if (armed) begin
            chk("level", 64'(level), 64'(q.size()));
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            if (q.size() == 0 && fresh)
                chk("out_data_reset", out_data, NOP);
            if (out_valid && out_ready && !stall && !reset && q.size() > 0) begin
                exp_d = q.pop_front();
                chk("out_data", out_data, exp_d);
            end
        end
        if (reset || (flush && armed)) begin
            q.delete();
            fresh = 1;
            if (reset) armed = 1;
        end
    end

    // Drive one cycle of inputs; the payload is recorded as accepted at the edge it is taken.
    task automatic step(input logic iv, input logic [63:0] d, input logic ordy,
                        input logic st, input logic fl, input logic rs);
        bit pend;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        reset     = rs;
        pend = iv && (q.size() < 2) && !fl && !rs;
        @(posedge clk);
        if (pend) begin
            q.push_back(d);
            fresh = 0;
        end
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk); #1;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        // Streaming at full rate
        for (int i = 0; i < 4; i++) step(1, 64'hA0 + 64'(i), 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);

        // Backpressure fills the skid, third payload held upstream
        step(1, 64'h11, 0, 0, 0, 0);
        step(1, 64'h22, 0, 0, 0, 0);
        step(1, 64'h33, 0, 0, 0, 0);
        step(1, 64'h33, 1, 0, 0, 0);
        step(1, 64'h33, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);

        // Flush while full
        step(1, 64'h11, 0, 0, 0, 0);
        step(1, 64'h22, 0, 0, 0, 0);
        step(1, 64'h77, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);

        // Stall holds the output
        step(0, 0, 1, 0, 0, 1);
        step(1, 64'h44, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);

        // Reset coinciding with push and pop
        step(1, 64'h66, 1, 0, 0, 0);
        step(1, 64'h55, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            step(($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 4) != 0,
                 ($urandom % 8) == 0, ($urandom % 64) == 0, ($urandom % 256) == 0);
        end

        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);
        chk("drained", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
